misr_response_analyzer: RTL and testbench

- BIST response-side block. Compacts the primary-output responses of a circuit under test (e.g. the gate-level adder's {carry, sum}) into a signature using a multiple-input signature register (MISR).
- Compares the final signature against a golden value and reports pass/fail.
- It is the receiving end of the pattern/response path. The pattern generator drives the CUT inputs; this block consumes the CUT outputs through a valid/ready handshake.

---
 rtl/misr_response_analyzer_if.sv | 11 +
 rtl/misr_response_analyzer.sv | 104 ++++++++++
 tb/tb_misr_response_analyzer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/misr_response_analyzer_if.sv
// Response handshake between the circuit under test and the MISR analyzer.
interface misr_response_analyzer_if #(
  parameter int unsigned IN_W = 2
) ();
  logic            resp_valid;
  logic [IN_W-1:0] resp_data;
  logic            resp_ready;

  modport master (output resp_valid, output resp_data, input resp_ready);
  modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/misr_response_analyzer.sv
// BIST response analyzer: compacts CUT response beats into a MISR signature and
// compares the final signature with a golden value latched at start.
module misr_response_analyzer #(
  parameter int unsigned       IN_W  = 2,
  parameter int unsigned       SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED  = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               pat_count,
  input  logic [SIG_W-1:0]          golden,
  misr_response_analyzer_if.slave   resp,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [SIG_W-1:0]          signature,
  output logic [15:0]               beat_cnt
);

  if (IN_W < 1 || IN_W > SIG_W) begin : g_param_check
    $error("IN_W must be in 1..SIG_W");
  end

  typedef enum logic [1:0] {StIdle, StCapture, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] gold_q, gold_d;
  logic [15:0]      pat_q, pat_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             ready;
  logic [SIG_W-1:0] feedback;
  logic [SIG_W-1:0] misr_next;

  // Shift toward the MSB; the bit shifted out selects the polynomial feedback.
  assign feedback  = sig_q[SIG_W-1] ? POLY : '0;
  assign misr_next = (sig_q << 1) ^ feedback ^ SIG_W'(resp.resp_data);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    gold_d  = gold_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    ready   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          pat_d   = pat_count;
          gold_d  = golden;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = (pat_count != 16'd0) ? StCapture : StCheck;
        end
      end
      StCapture: begin
        ready = 1'b1;
        if (resp.resp_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == pat_q) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        pass_d  = (sig_q == gold_q);
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      gold_q  <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      gold_q  <= gold_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign resp.resp_ready = ready;
  assign busy            = (state_q == StCapture) || (state_q == StCheck);
  assign done            = (state_q == StDone);
  assign pass            = pass_q;
  assign signature       = sig_q;
  assign beat_cnt        = cnt_q;

endmodule

// File: tb/tb_misr_response_analyzer.sv
// Randomized and directed bench for misr_response_analyzer with a polynomial-arithmetic model.
module tb_misr_response_analyzer;

  localparam logic [15:0] Poly = 16'h1021;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [15:0] pat_count, pat_count2;
  logic [15:0] golden, golden2;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [15:0] signature, signature2, beat_cnt, beat_cnt2;

  int vecs = 0;
  int errs = 0;

  misr_response_analyzer_if #(.IN_W(2)) bus ();
  misr_response_analyzer_if #(.IN_W(2)) bus2 ();

  misr_response_analyzer dut (
    .clk(clk), .rst(rst), .start(start), .pat_count(pat_count), .golden(golden),
    .resp(bus), .busy(busy), .done(done), .pass(pass), .signature(signature),
    .beat_cnt(beat_cnt)
  );

  misr_response_analyzer #(.SEED(16'h8000)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pat_count(pat_count2), .golden(golden2),
    .resp(bus2), .busy(busy2), .done(done2), .pass(pass2), .signature(signature2),
    .beat_cnt(beat_cnt2)
  );

  always #5 clk = ~clk;

  // Signature step as polynomial arithmetic: multiply by x modulo p(x), then add the beat.
  function automatic logic [15:0] model_step(logic [15:0] s, logic [1:0] d);
    int unsigned v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ int'(Poly);
    return 16'(v ^ int'(d));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] pc, input logic [15:0] g);
    start = 1'b1; pat_count = pc; golden = g;
    tick();
    start = 1'b0; pat_count = 16'($urandom); golden = 16'($urandom);
  endtask

  task automatic test_reset();
    vecs++;
    if ({busy, done, pass, bus.resp_ready, signature, beat_cnt} !== 20'h0) begin
      errs++; $display("FAIL reset_state got %h want 0", {busy, done, pass, bus.resp_ready, signature, beat_cnt});
    end
    vecs++;
    if (signature2 !== 16'h8000) begin
      errs++; $display("FAIL reset_seed got %h want 8000", signature2);
    end
    start_run(16'd5, 16'h0);
    bus.resp_valid = 1'b1; bus.resp_data = 2'b11;
    tick();
    bus.resp_valid = 1'b0;
    vecs++;
    if (signature !== 16'h0003 || beat_cnt !== 16'd1) begin
      errs++; $display("FAIL pre_reset_beat got sig %h cnt %0d want 0003 1", signature, beat_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({busy, done, pass, bus.resp_ready, signature, beat_cnt} !== 20'h0) begin
      errs++; $display("FAIL midrun_reset got %h want 0", {busy, done, pass, bus.resp_ready, signature, beat_cnt});
    end
    // Still idle: offered beats must not be absorbed.
    bus.resp_valid = 1'b1; bus.resp_data = 2'b01;
    tick(); tick();
    bus.resp_valid = 1'b0;
    vecs++;
    if (signature !== 16'h0 || beat_cnt !== 16'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL idle_no_absorb got sig %h cnt %0d busy %b want 0 0 0", signature, beat_cnt, busy);
    end
  endtask

  task automatic test_single_beat();
    start_run(16'd1, 16'h0001);
    vecs++;
    if (bus.resp_ready !== 1'b1 || busy !== 1'b1) begin
      errs++; $display("FAIL single_ready got %b busy %b want 1 1", bus.resp_ready, busy);
    end
    bus.resp_valid = 1'b1; bus.resp_data = 2'b01;
    tick();
    bus.resp_valid = 1'b0;
    vecs++;
    if (signature !== 16'h0001 || bus.resp_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL single_check got sig %h rdy %b done %b busy %b want 0001 0 0 1",
                       signature, bus.resp_ready, done, busy);
    end
    tick();
    vecs++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || beat_cnt !== 16'd1) begin
      errs++; $display("FAIL single_done got done %b pass %b busy %b cnt %0d want 1 1 0 1",
                       done, pass, busy, beat_cnt);
    end
  endtask

  task automatic test_cancel();
    for (int k = 0; k < 2; k++) begin
      start_run(16'd2, (k == 0) ? 16'h0000 : 16'h0001);
      bus.resp_valid = 1'b1; bus.resp_data = 2'b01;
      tick();
      vecs++;
      if (signature !== 16'h0001) begin
        errs++; $display("FAIL cancel_beat1 got %h want 0001", signature);
      end
      bus.resp_data = 2'b10;
      tick();
      bus.resp_valid = 1'b0;
      vecs++;
      if (signature !== 16'h0000) begin
        errs++; $display("FAIL cancel_beat2 got %h want 0000", signature);
      end
      tick();
      vecs++;
      if (done !== 1'b1 || pass !== (k == 0)) begin
        errs++; $display("FAIL cancel_pass%0d got done %b pass %b want 1 %b", k, done, pass, k == 0);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp_sig [3] = '{16'h0003, 16'h0005, 16'h0009};
    start_run(16'd3, 16'h0009);
    for (int i = 0; i < 3; i++) begin
      bus.resp_valid = 1'b0;
      tick(); tick();
      vecs++;
      if (beat_cnt !== 16'(i) || bus.resp_ready !== 1'b1) begin
        errs++; $display("FAIL stall_gap%0d got cnt %0d rdy %b want %0d 1", i, beat_cnt, bus.resp_ready, i);
      end
      bus.resp_valid = 1'b1; bus.resp_data = 2'b11;
      tick();
      vecs++;
      if (signature !== exp_sig[i] || beat_cnt !== 16'(i + 1)) begin
        errs++; $display("FAIL stall_beat%0d got sig %h cnt %0d want %h %0d",
                         i, signature, beat_cnt, exp_sig[i], i + 1);
      end
    end
    bus.resp_valid = 1'b0;
    tick();
    vecs++;
    if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'h0009) begin
      errs++; $display("FAIL stall_done got done %b pass %b sig %h want 1 1 0009", done, pass, signature);
    end
  endtask

  task automatic test_feedback();
    start2 = 1'b1; pat_count2 = 16'd1; golden2 = 16'h1021;
    tick();
    start2 = 1'b0;
    vecs++;
    if (signature2 !== 16'h8000 || bus2.resp_ready !== 1'b1) begin
      errs++; $display("FAIL fb_start got sig %h rdy %b want 8000 1", signature2, bus2.resp_ready);
    end
    bus2.resp_valid = 1'b1; bus2.resp_data = 2'b00;
    tick();
    bus2.resp_valid = 1'b0;
    tick();
    vecs++;
    if (signature2 !== 16'h1021 || done2 !== 1'b1 || pass2 !== 1'b1) begin
      errs++; $display("FAIL fb_tap got sig %h done %b pass %b want 1021 1 1", signature2, done2, pass2);
    end
  endtask

  task automatic test_zero_count();
    int saw_ready = 0;
    bus.resp_valid = 1'b1; bus.resp_data = 2'b11;
    if (bus.resp_ready) saw_ready++;
    start_run(16'd0, 16'h0000);
    if (bus.resp_ready) saw_ready++;
    vecs++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL zero_check got busy %b done %b want 1 0", busy, done);
    end
    tick();
    if (bus.resp_ready) saw_ready++;
    bus.resp_valid = 1'b0;
    vecs++;
    if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'h0 || beat_cnt !== 16'd0 || saw_ready != 0) begin
      errs++; $display("FAIL zero_done got done %b pass %b sig %h cnt %0d ready_seen %0d want 1 1 0 0 0",
                       done, pass, signature, beat_cnt, saw_ready);
    end
  endtask

  task automatic test_start_ignored();
    start_run(16'd2, 16'h0007);
    start = 1'b1; pat_count = 16'd7; golden = 16'h0;
    bus.resp_valid = 1'b1; bus.resp_data = 2'b11;
    tick();
    bus.resp_data = 2'b01;
    tick();
    bus.resp_valid = 1'b0;
    vecs++;
    if (signature !== 16'h0007 || beat_cnt !== 16'd2 || busy !== 1'b1) begin
      errs++; $display("FAIL ignore_capture got sig %h cnt %0d busy %b want 0007 2 1", signature, beat_cnt, busy);
    end
    tick();
    start = 1'b0;
    vecs++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errs++; $display("FAIL ignore_done got done %b pass %b want 1 1", done, pass);
    end
  endtask

  task automatic test_restart();
    start_run(16'd1, 16'h0002);
    vecs++;
    if (done !== 1'b0 || signature !== 16'h0 || beat_cnt !== 16'd0 || pass !== 1'b0 || bus.resp_ready !== 1'b1) begin
      errs++; $display("FAIL restart got done %b sig %h cnt %0d pass %b rdy %b want 0 0 0 0 1",
                       done, signature, beat_cnt, pass, bus.resp_ready);
    end
    bus.resp_valid = 1'b1; bus.resp_data = 2'b10;
    tick();
    bus.resp_valid = 1'b0;
    tick();
    vecs++;
    if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'h0002) begin
      errs++; $display("FAIL restart_done got done %b pass %b sig %h want 1 1 0002", done, pass, signature);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      int unsigned pc;
      logic [15:0] exp_sig;
      logic [15:0] g;
      logic        match;
      logic [1:0]  d;
      pc = $urandom_range(0, 8);
      exp_sig = 16'h0;
      d = 2'b00;
      match = 1'($urandom);
      g = 16'h0;
      start_run(16'(pc), 16'h0);
      // Golden is only known after the beats are chosen, so restart with a pre-computed stream.
      begin
        logic [1:0] beats [$];
        for (int i = 0; i < int'(pc); i++) begin
          d = 2'($urandom);
          beats.push_back(d);
          exp_sig = model_step(exp_sig, d);
        end
        g = match ? exp_sig : (exp_sig ^ (16'h1 << $urandom_range(0, 15)));
        // Drain the provisional run so the block is in DONE, then start the real one.
        for (int i = 0; i < int'(pc); i++) begin
          bus.resp_valid = 1'b1; bus.resp_data = 2'b00;
          tick();
        end
        bus.resp_valid = 1'b0;
        tick();
        start_run(16'(pc), g);
        for (int i = 0; i < int'(pc); i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          bus.resp_valid = 1'b0;
          for (int k = 0; k < gap; k++) tick();
          bus.resp_valid = 1'b1; bus.resp_data = beats[i];
          tick();
          vecs++;
          if (beat_cnt !== 16'(i + 1)) begin
            errs++; $display("FAIL rand%0d_cnt%0d got %0d want %0d", r, i, beat_cnt, i + 1);
          end
        end
        bus.resp_valid = 1'b0;
      end
      vecs++;
      if (busy !== 1'b1 || done !== 1'b0 || signature !== exp_sig) begin
        errs++; $display("FAIL rand%0d_check got busy %b done %b sig %h want 1 0 %h",
                         r, busy, done, signature, exp_sig);
      end
      tick();
      vecs++;
      if (done !== 1'b1 || pass !== match || signature !== exp_sig) begin
        errs++; $display("FAIL rand%0d_done got done %b pass %b sig %h want 1 %b %h",
                         r, done, pass, signature, match, exp_sig);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; pat_count = 16'h0; golden = 16'h0;
    start2 = 1'b0; pat_count2 = 16'h0; golden2 = 16'h0;
    bus.resp_valid = 1'b0; bus.resp_data = 2'b00;
    bus2.resp_valid = 1'b0; bus2.resp_data = 2'b00;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_single_beat();
    test_cancel();
    test_stall();
    test_feedback();
    test_zero_count();
    test_start_ignored();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
